// File: rtl/enigma_pkg.sv
// Shared constants, mod-A helpers and stock rotor data for the
// programmable rotor stack.
package enigma_pkg;

   localparam int ALPHA = 26;
   localparam int SYMW  = 5;

   typedef enum logic {
      ST_IDLE,
      ST_LOAD
   } cfg_state_e;

   function automatic logic [7:0] mod_add(
      input logic [7:0] a,
      input logic [7:0] b,
      input logic [7:0] m
   );
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, m}) s = s - {1'b0, m};
      return s[7:0];
   endfunction

   function automatic logic [7:0] mod_sub(
      input logic [7:0] a,
      input logic [7:0] b,
      input logic [7:0] m
   );
      logic [8:0] s;
      if (a >= b) s = {1'b0, a} - {1'b0, b};
      else        s = {1'b0, a} + {1'b0, m} - {1'b0, b};
      return s[7:0];
   endfunction

   // Stock wirings, left-side letter for right-side A..Z
   localparam logic [8*26-1:0] ROTOR_I   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
   localparam logic [8*26-1:0] ROTOR_II  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
   localparam logic [8*26-1:0] ROTOR_III = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
   localparam logic [8*26-1:0] ROTOR_IV  = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
   localparam logic [8*26-1:0] ROTOR_V   = "VZBRGITYUPSDNHLXAWMJQOFECK";

   localparam logic [4:0] NOTCH_I   = 5'd16;
   localparam logic [4:0] NOTCH_II  = 5'd4;
   localparam logic [4:0] NOTCH_III = 5'd21;
   localparam logic [4:0] NOTCH_IV  = 5'd9;
   localparam logic [4:0] NOTCH_V   = 5'd25;

endpackage

// File: rtl/rotor_modadd.sv
// Modular add or subtract of two symbols already reduced mod A.
// The intermediate is one bit wider so the wrap never overflows.
module rotor_modadd #(
   parameter int A   = 26,
   parameter int W   = 5,
   parameter bit SUB = 1'b0
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_y
);

   localparam logic [W:0] M = (W+1)'(A);

   logic [W:0] w_sum;

   always_comb begin
      w_sum = '0;
      if (SUB) begin
         if (i_a >= i_b) w_sum = {1'b0, i_a} - {1'b0, i_b};
         else            w_sum = {1'b0, i_a} + M - {1'b0, i_b};
      end else begin
         w_sum = {1'b0, i_a} + {1'b0, i_b};
      end
      if (w_sum >= M) o_y = W'(w_sum - M);
      else            o_y = w_sum[W-1:0];
   end

endmodule

// File: rtl/rotor_prog.sv
// Programmable Enigma rotor: runtime wiring tables with inverse,
// ring setting, position, notch mask and a wiring-reload FSM.
module rotor_prog
   import enigma_pkg::*;
#(
   parameter int A = ALPHA,
   parameter int W = SYMW
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         cfg_start,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [W-1:0] cfg_addr,
   input  logic [W-1:0] cfg_data,
   output logic         cfg_done,
   output logic         cfg_err,
   input  logic         notch_we,
   input  logic [A-1:0] notch_in,
   input  logic         ring_we,
   input  logic [W-1:0] ring_in,
   input  logic         pos_load,
   input  logic [W-1:0] pos_in,
   input  logic         step,
   output logic [W-1:0] pos,
   output logic         at_notch,
   output logic         carry_out,
   input  logic [W-1:0] right_in,
   output logic [W-1:0] left_out,
   input  logic [W-1:0] left_in,
   output logic [W-1:0] right_out,
   output logic         wiring_ok
);

   localparam logic [W:0]   LA        = (W+1)'(A);
   localparam logic [W-1:0] LAST_POS  = W'(A - 1);
   localparam logic [A-1:0] NOTCH_RST = {1'b1, {(A-1){1'b0}}};

   cfg_state_e r_state;
   cfg_state_e w_state_nxt;

   logic [W-1:0] r_fwd [A];
   logic [W-1:0] r_inv [A];
   logic [A-1:0] r_seen;
   logic [W:0]   r_cnt;
   logic         r_err;
   logic         r_ok;
   logic         r_done;

   logic [W-1:0] r_pos;
   logic [W-1:0] r_ring;
   logic [A-1:0] r_notch;

   logic         w_restart;
   logic         w_hs;
   logic         w_bad;
   logic         w_last;
   logic         w_err_nxt;
   logic [W:0]   w_cnt_nxt;

   logic         w_ca_ok;
   logic         w_cd_ok;
   logic [W-1:0] w_ca;
   logic [W-1:0] w_cd;

   logic         w_rin_ok;
   logic         w_lin_ok;
   logic [W-1:0] w_rin;
   logic [W-1:0] w_lin;
   logic [W-1:0] w_off;
   logic [W-1:0] w_p;
   logic [W-1:0] w_q;
   logic [W-1:0] w_fwd_val;
   logic [W-1:0] w_inv_val;
   logic [W-1:0] w_left;
   logic [W-1:0] w_right;

   // Out-of-range config fields are steered to entry 0 so no
   // table index ever leaves the alphabet; the beat is dropped.
   assign w_ca_ok = ({1'b0, cfg_addr} < LA);
   assign w_cd_ok = ({1'b0, cfg_data} < LA);
   assign w_ca    = w_ca_ok ? cfg_addr : '0;
   assign w_cd    = w_cd_ok ? cfg_data : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_restart   = 1'b0;
      w_hs        = 1'b0;
      w_bad       = 1'b0;
      w_last      = 1'b0;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_err_nxt   = r_err;
      unique case (r_state)
         ST_IDLE: begin
            if (en && cfg_start) begin
               w_state_nxt = ST_LOAD;
               w_restart   = 1'b1;
            end
         end
         ST_LOAD: begin
            if (en && cfg_start) begin
               w_restart = 1'b1;
            end else if (en && cfg_valid) begin
               w_hs      = 1'b1;
               w_bad     = !w_ca_ok || !w_cd_ok || r_seen[w_cd];
               w_err_nxt = r_err | w_bad;
               w_last    = (w_cnt_nxt == LA);
               if (w_last) w_state_nxt = ST_IDLE;
            end
         end
      endcase
   end

   assign cfg_ready = (r_state == ST_LOAD) && en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seen <= '0;
         r_cnt  <= '0;
         r_err  <= 1'b0;
         r_ok   <= 1'b1;
         r_done <= 1'b0;
         for (int i = 0; i < A; i++) begin
            r_fwd[i] <= W'(i);
            r_inv[i] <= W'(i);
         end
      end else begin
         r_done <= 1'b0;
         if (w_restart) begin
            r_seen <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
            r_ok   <= 1'b0;
         end else if (w_hs) begin
            r_cnt <= w_cnt_nxt;
            r_err <= w_err_nxt;
            if (!w_bad) begin
               r_fwd[w_ca]  <= cfg_data;
               r_inv[w_cd]  <= cfg_addr;
               r_seen[w_cd] <= 1'b1;
            end
            if (w_last) begin
               r_done <= 1'b1;
               r_ok   <= ~w_err_nxt;
            end
         end
      end
   end

   assign cfg_done  = r_done;
   assign cfg_err   = r_err;
   assign wiring_ok = r_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pos   <= '0;
         r_ring  <= '0;
         r_notch <= NOTCH_RST;
      end else if (en) begin
         if (pos_load) begin
            r_pos <= ({1'b0, pos_in} < LA) ? pos_in : '0;
         end else if (step) begin
            r_pos <= (r_pos == LAST_POS) ? '0 : r_pos + 1'b1;
         end
         if (ring_we) begin
            r_ring <= ({1'b0, ring_in} < LA) ? ring_in : '0;
         end
         if (notch_we) r_notch <= notch_in;
      end
   end

   assign pos       = r_pos;
   assign at_notch  = r_notch[r_pos];
   assign carry_out = en & step & at_notch;

   assign w_off = W'(mod_sub(8'(r_pos), 8'(r_ring), 8'(A)));

   assign w_rin_ok = ({1'b0, right_in} < LA);
   assign w_lin_ok = ({1'b0, left_in} < LA);
   assign w_rin    = w_rin_ok ? right_in : '0;
   assign w_lin    = w_lin_ok ? left_in : '0;

   rotor_modadd #(.A(A), .W(W), .SUB(1'b0)) u_fwd_in (
      .i_a (w_rin),
      .i_b (w_off),
      .o_y (w_p)
   );

   assign w_fwd_val = r_fwd[w_p];

   rotor_modadd #(.A(A), .W(W), .SUB(1'b1)) u_fwd_out (
      .i_a (w_fwd_val),
      .i_b (w_off),
      .o_y (w_left)
   );

   rotor_modadd #(.A(A), .W(W), .SUB(1'b0)) u_ret_in (
      .i_a (w_lin),
      .i_b (w_off),
      .o_y (w_q)
   );

   assign w_inv_val = r_inv[w_q];

   rotor_modadd #(.A(A), .W(W), .SUB(1'b1)) u_ret_out (
      .i_a (w_inv_val),
      .i_b (w_off),
      .o_y (w_right)
   );

   assign left_out  = w_rin_ok ? w_left : '1;
   assign right_out = w_lin_ok ? w_right : '1;

endmodule

// File: doc/rotor_prog.md
Name: rotor_prog

Overview:
- Next-generation Enigma rotor. Wiring, ring setting, position and notch set are all runtime-programmable, and the alphabet size is parametrised.
- A forward wiring table and its inverse are kept in registers, so both the right-to-left and the left-to-right paths are exact lookups.
- Sits in the rotor stack between the stepping controller and the plugboard/reflector path. One instance per rotor slot.

Parameters:
- A, 26, alphabet size (2..32).
- W, 5, symbol width; must satisfy 2**W >= A.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  gates all state updates except reset.
- cfg_start  in  1  begin a wiring reload.
- cfg_valid  in  1  wiring entry present.
- cfg_ready  out  1  block accepts wiring entries.
- cfg_addr  in  W  right-side contact index.
- cfg_data  in  W  left-side contact wired to cfg_addr.
- cfg_done  out  1  one-cycle pulse when the reload finishes.
- cfg_err  out  1  sticky flag: the last reload was not a bijection.
- notch_we  in  1  write the notch mask.
- notch_in  in  A  notch mask, bit k = turnover at position k.
- ring_we  in  1  write the ring setting.
- ring_in  in  W  ring setting (Ringstellung).
- pos_load  in  1  load the rotor position.
- pos_in  in  W  position to load.
- step  in  1  advance the position by one.
- pos  out  W  current position.
- at_notch  out  1  notch_mask[pos].
- carry_out  out  1  en & step & at_notch; steps the next rotor.
- right_in  in  W  forward path input.
- left_out  out  W  forward path output.
- left_in  in  W  return path input.
- right_out  out  W  return path output.
- wiring_ok  out  1  tables valid; the data paths are meaningful.

Behaviour:
- Reset (async, rst_n=0) values:
  - fwd[i] = inv[i] = i (identity wiring); pos = 0; ring = 0; notch mask = 1<<(A-1).
  - FSM = IDLE; cfg_ready = 0; cfg_done = 0; cfg_err = 0; wiring_ok = 1.
- All arithmetic is mod A on W-bit values; no operand exceeds 2A-2 before reduction. The offset is off = (pos - ring) mod A.
- Forward path (combinational, 0 latency):
  - p = (right_in + off) mod A.
  - left_out = (fwd[p] - off) mod A.
- Return path (combinational):
  - q = (left_in + off) mod A.
  - right_out = (inv[q] - off) mod A.
- Any data input >= A produces an all-ones output on that path.
- Position update, only when en=1, in priority order:
  - pos_load: pos <= pos_in, or 0 if pos_in >= A.
  - else step: pos <= (pos == A-1) ? 0 : pos + 1.
- ring_we and notch_we act independently, also gated by en. A ring_in value >= A loads 0.
- Config FSM, states IDLE and LOAD; transitions occur only when en=1:
  - IDLE: cfg_start -> LOAD. On entry: clear seen[A-1:0], clear cnt, wiring_ok <= 0, cfg_err <= 0.
  - LOAD: cfg_ready = 1. A handshake (cfg_valid & cfg_ready) writes fwd[cfg_addr] <= cfg_data and inv[cfg_data] <= cfg_addr, sets seen[cfg_data], and increments cnt.
  - Error condition: cfg_addr >= A, cfg_data >= A, or seen[cfg_data] already set. The entry is dropped and cfg_err <= 1, but cnt still increments.
  - When cnt reaches A: return to IDLE, pulse cfg_done for 1 cycle, and set wiring_ok <= ~cfg_err_next (error state including the final beat).
  - cfg_start while in LOAD restarts the load (seen and cnt are cleared).
  - Duplicate cfg_addr values are not detected directly. They necessarily produce a duplicate or missing cfg_data, which flags the error.
- While wiring_ok = 0, the data outputs follow the current table contents. Downstream must ignore them.
- Stepping and position load stay functional during LOAD.
- Reset mid-LOAD abandons the load and restores the identity wiring.

Decomposition:
- Shared package enigma_pkg holds:
  - the alphabet size constant;
  - the symbol width;
  - the mod-A add/subtract functions;
  - the stock rotor I–V wiring constants and notch constants for benches.
- One sub-module, rotor_modadd (a + b or a - b mod A, parametrised). It is instantiated four times for the two path offsets in and the two offsets out.
- The config FSM and the tables stay in the top level.

Test Plan:
- Reset only -> right_in = 7 gives left_out = 7; left_in = 20 gives right_out = 20; pos = 0; wiring_ok = 1; at_notch = 0.
- Load rotor I "EKMFLGDQVZNTOWYHXUSPAIBRCJ" as 26 beats, with cfg_valid toggling to exercise the handshake; notch mask = 1<<16 -> cfg_done pulses, wiring_ok = 1.
  - pos = 0, ring = 0: right_in = 0 -> left_out = 4; left_in = 4 -> right_out = 0.
- Rotor I loaded, pos_load = 1 (B), ring = 0: right_in = 0 -> left_out = 9 (A->J).
  - Same with ring = 1 and pos = 1: A -> E (4).
- Step from pos 15 with en = 1: at 16 (Q), at_notch = 1 and carry_out = step.
  - Step from 25 -> pos wraps to 0.
  - pos_load and step together -> pos_load wins.
- Reload with a duplicate cfg_data = 4 at addrs 0 and 1 -> cfg_err = 1 after the beat; cfg_done pulses after 26 beats; wiring_ok = 0.
  - A subsequent clean reload clears cfg_err and restores wiring_ok = 1.
- rst_n asserted after 10 LOAD beats -> immediately cfg_ready = 0, wiring_ok = 1, identity mapping; right_in = 26 -> left_out = 31.
